vx_stream_sel_arb: RTL and testbench

Round-robin select generator that sits directly upstream of the stream switch's select port when the switch narrows (NUM_INPUTS > NUM_OUTPUTS). It watches the switch's input-side `valid`/`ready` pairs, picks one requester per output group, and drives `sel_out` into the switch's `sel_in`. Each group gets fair rotation. An optional grant lock keeps `sel_out` stable while a selected transfer is stalled, so the switch output never changes under backpressure.

---
 rtl/vx_stream_sel_arb.sv | 117 +++++++++++
 tb/tb_vx_stream_sel_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_stream_sel_arb.sv
// vx_stream_sel_arb: per-group round-robin select generator that drives the sel_in port of a narrowing stream switch.
// Optional grant lock (hold the select while the granted transfer is stalled) is built when STREAM_SEL_ARB_LOCK_EN is defined.
module vx_stream_sel_arb #(
  parameter  int NUM_INPUTS   = 4,
  parameter  int NUM_OUTPUTS  = 1,
  parameter  int NUM_REQS     = (NUM_INPUTS + NUM_OUTPUTS - 1) / NUM_OUTPUTS,
  parameter  int LOG_NUM_REQS = $clog2(NUM_REQS),
  localparam int SEL_W        = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_INPUTS-1:0]               valid_in,
  input  logic [NUM_INPUTS-1:0]               ready_in,
  output logic [NUM_OUTPUTS-1:0][SEL_W-1:0]   sel_out,
  output logic [NUM_OUTPUTS-1:0]              grant_valid
);

  localparam int               PAD_W    = NUM_OUTPUTS * NUM_REQS;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQS - 1);

  // Inputs beyond NUM_INPUTS exist only as tied-off slots of the last group.
  logic [PAD_W-1:0] valid_pad;
  logic [PAD_W-1:0] ready_pad;

  always_comb begin
    valid_pad = '0;
    ready_pad = '0;
    valid_pad[NUM_INPUTS-1:0] = valid_in;
    ready_pad[NUM_INPUTS-1:0] = ready_in;
  end

  for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_grp
    logic [NUM_REQS-1:0] req_valid;
    logic [NUM_REQS-1:0] req_ready;
    logic [SEL_W-1:0]    ptr_reg;
    logic [SEL_W-1:0]    ptr_next;
    logic [SEL_W-1:0]    scan_sel;
    logic [SEL_W-1:0]    cur_sel;
    logic                cur_valid;
    logic                cur_ready;
    logic                fire;

    assign req_valid = valid_pad[gi*NUM_REQS +: NUM_REQS];
    assign req_ready = ready_pad[gi*NUM_REQS +: NUM_REQS];

    // Lowest valid index at or above ptr wins; failing that, the lowest valid
    // index overall (the wrapped part of the rotation). No valid -> hold ptr.
    always_comb begin
      scan_sel = ptr_reg;
      for (int j = NUM_REQS - 1; j >= 0; j--) begin
        if (req_valid[j]) scan_sel = SEL_W'(j);
      end
      for (int j = NUM_REQS - 1; j >= 0; j--) begin
        if (req_valid[j] && (j >= int'(ptr_reg))) scan_sel = SEL_W'(j);
      end
    end

    always_comb begin
      cur_valid = 1'b0;
      cur_ready = 1'b0;
      for (int j = 0; j < NUM_REQS; j++) begin
        if (cur_sel == SEL_W'(j)) begin
          cur_valid = req_valid[j];
          cur_ready = req_ready[j];
        end
      end
    end

    assign fire     = cur_valid & cur_ready;
    assign ptr_next = (cur_sel == LAST_IDX) ? '0 : cur_sel + SEL_W'(1);

    // While reset is held the select is pinned to slot 0 of each group.
    assign sel_out[gi]     = reset ? cur_sel : '0;
    assign grant_valid[gi] = reset ? cur_valid : req_valid[0];

`ifdef STREAM_SEL_ARB_LOCK_EN
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_reg;
    logic [SEL_W-1:0] lock_idx_reg;

    assign cur_sel = (state_reg == ST_LOCKED) ? lock_idx_reg : scan_sel;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ptr_reg      <= '0;
        state_reg    <= ST_IDLE;
        lock_idx_reg <= '0;
      end else if (fire) begin
        // A fire always wins over entering or holding the lock.
        ptr_reg   <= ptr_next;
        state_reg <= ST_IDLE;
      end else if (state_reg == ST_IDLE) begin
        if (cur_valid) begin
          state_reg    <= ST_LOCKED;
          lock_idx_reg <= cur_sel;
        end
      end else if (!cur_valid) begin
        // Source withdrew valid while held: release without moving ptr.
        state_reg <= ST_IDLE;
      end
    end
`else
    assign cur_sel = scan_sel;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ptr_reg <= '0;
      end else if (fire) begin
        ptr_reg <= ptr_next;
      end
    end
`endif
  end

endmodule

// File: tb/tb_vx_stream_sel_arb.sv
// Bench for vx_stream_sel_arb: an 8-in/2-group instance and a 5-in/2-group instance (3 slots, one tied off)
// checked every cycle against a queue-free rotation model, plus directed literal expectations.
module tb_vx_stream_sel_arb;

`ifdef STREAM_SEL_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic            clk   = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      va    = '0;
  logic [7:0]      ra    = '0;
  logic [4:0]      vb    = '0;
  logic [4:0]      rb    = '0;
  logic [1:0][1:0] sel_a;
  logic [1:0][1:0] sel_b;
  logic [1:0]      gv_a;
  logic [1:0]      gv_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vx_stream_sel_arb #(.NUM_INPUTS(8), .NUM_OUTPUTS(2)) u_a (
    .clk(clk), .reset(reset), .valid_in(va), .ready_in(ra),
    .sel_out(sel_a), .grant_valid(gv_a)
  );

  vx_stream_sel_arb #(.NUM_INPUTS(5), .NUM_OUTPUTS(2)) u_b (
    .clk(clk), .reset(reset), .valid_in(vb), .ready_in(rb),
    .sel_out(sel_b), .grant_valid(gv_b)
  );

  // ---------------- reference model ----------------
  int m_ptr  [2][2];
  bit m_lk   [2][2];
  int m_lidx [2][2];
  int n_req  [2] = '{4, 3};
  int n_in   [2] = '{8, 5};

  function automatic bit in_v(int inst, int a);
    logic [7:0] v;
    v = (inst == 0) ? va : {3'b000, vb};
    return (a < n_in[inst]) ? v[a[2:0]] : 1'b0;
  endfunction

  function automatic bit in_r(int inst, int a);
    logic [7:0] r;
    r = (inst == 0) ? ra : {3'b000, rb};
    return (a < n_in[inst]) ? r[a[2:0]] : 1'b0;
  endfunction

  function automatic int exp_sel(int inst, int g);
    int n;
    n = n_req[inst];
    if (!reset) return 0;
    if (m_lk[inst][g]) return m_lidx[inst][g];
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (m_ptr[inst][g] + k) % n;
      if (in_v(inst, g * n + idx)) return idx;
    end
    return m_ptr[inst][g];
  endfunction

  function automatic int exp_gv(int inst, int g);
    return int'(in_v(inst, g * n_req[inst] + exp_sel(inst, g)));
  endfunction

  function automatic int act_sel(int inst, int g);
    return (inst == 0) ? int'(sel_a[g[0]]) : int'(sel_b[g[0]]);
  endfunction

  function automatic int act_gv(int inst, int g);
    return (inst == 0) ? int'(gv_a[g[0]]) : int'(gv_b[g[0]]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int g = 0; g < 2; g++) begin
        m_ptr[i][g]  = 0;
        m_lk[i][g]   = 1'b0;
        m_lidx[i][g] = 0;
      end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++)
      for (int g = 0; g < 2; g++) begin
        int n, s, a;
        bit v, r;
        n = n_req[i];
        s = exp_sel(i, g);
        a = g * n + s;
        v = in_v(i, a);
        r = in_r(i, a);
        if (v && r) begin
          m_ptr[i][g] = (s + 1) % n;
          m_lk[i][g]  = 1'b0;
        end else if (m_lk[i][g]) begin
          if (!v) m_lk[i][g] = 1'b0;
        end else if (v && LOCK) begin
          m_lk[i][g]   = 1'b1;
          m_lidx[i][g] = s;
        end
      end
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!reset) model_clear();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) model_clear();
      for (int i = 0; i < 2; i++)
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("cyc_sel i%0d g%0d", i, g), act_sel(i, g), exp_sel(i, g));
          chk($sformatf("cyc_gv i%0d g%0d", i, g), act_gv(i, g), exp_gv(i, g));
        end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [7:0] va_n, input logic [7:0] ra_n,
                      input logic [4:0] vb_n, input logic [4:0] rb_n);
    @(posedge clk);
    #1;
    va = va_n; ra = ra_n; vb = vb_n; rb = rb_n;
    #1;
    $display("t=%0t va=%02h ra=%02h vb=%02h rb=%02h -> sel_a=%h gv_a=%b sel_b=%h gv_b=%b",
             $time, va, ra, vb, rb, sel_a, gv_a, sel_b, gv_b);
  endtask

  int rr   [6] = '{0, 1, 2, 3, 0, 1};
  int b_g0 [4] = '{0, 1, 2, 0};
  int b_g1 [4] = '{0, 1, 0, 1};

  initial begin
    model_clear();
    // Reset held with everything valid.
    step(8'hFF, 8'h00, 5'h00, 5'h00);
    step(8'hFF, 8'h00, 5'h00, 5'h00);
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_gv_a", int'(gv_a), 3);
    chk("rst_sel_b", int'(sel_b), 0);
    chk("rst_gv_b", int'(gv_b), 0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rel_sel_a", int'(sel_a), 0);
    chk("rel_gv_a", int'(gv_a), 3);
    step(8'hFF, 8'h00, 5'h00, 5'h00);
    chk("hold_sel_a", int'(sel_a), 0);
    chk("hold_gv_a", int'(gv_a), 3);

    // Round robin, every input valid and ready.
    for (int i = 0; i < 6; i++) begin
      step(8'hFF, 8'hFF, 5'h00, 5'h00);
      chk($sformatf("rr_sel0 #%0d", i), int'(sel_a[0]), rr[i]);
    end

    // Skip and wrap.
    step(8'h11, 8'hFF, 5'h00, 5'h00);
    chk("sw_first_sel0", int'(sel_a[0]), 0);
    step(8'h09, 8'hFF, 5'h00, 5'h00);
    chk("sw_skip_sel0", int'(sel_a[0]), 3);
    chk("sw_idle_sel1", int'(sel_a[1]), 1);
    chk("sw_gv_a", int'(gv_a), 1);
    step(8'h09, 8'hFF, 5'h00, 5'h00);
    chk("sw_wrap_sel0", int'(sel_a[0]), 0);

    // Stall on input 5 while input 6 joins.
    step(8'h20, 8'h00, 5'h00, 5'h00);
    chk("lk_sel1", int'(sel_a[1]), 1);
    for (int i = 0; i < 3; i++) begin
      step(8'h60, 8'h00, 5'h00, 5'h00);
      chk($sformatf("lk_stall_sel1 #%0d", i), int'(sel_a[1]), 1);
      chk($sformatf("lk_stall_gv1 #%0d", i), int'(gv_a[1]), 1);
    end
    step(8'h60, 8'h20, 5'h00, 5'h00);
    chk("lk_fire_sel1", int'(sel_a[1]), 1);
    step(8'h60, 8'h00, 5'h00, 5'h00);
    chk("lk_next_sel1", int'(sel_a[1]), 2);

    // Valid withdrawn while stalled.
    step(8'h60, 8'h40, 5'h00, 5'h00);
    step(8'h10, 8'hFF, 5'h00, 5'h00);
    chk("drop_setup_sel1", int'(sel_a[1]), 0);
    step(8'h60, 8'h00, 5'h00, 5'h00);
    chk("drop_pre_sel1", int'(sel_a[1]), 1);
    step(8'h40, 8'h00, 5'h00, 5'h00);
    chk("drop_same_sel1", int'(sel_a[1]), LOCK ? 1 : 2);
    step(8'h40, 8'h00, 5'h00, 5'h00);
    chk("drop_next_sel1", int'(sel_a[1]), 2);

    // Asynchronous reset during a group-0 stall at index 2.
    step(8'h04, 8'h00, 5'h00, 5'h00);
    chk("mid_pre_sel0", int'(sel_a[0]), 2);
    step(8'h04, 8'h00, 5'h00, 5'h00);
    chk("mid_stall_sel0", int'(sel_a[0]), 2);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_sel_a", int'(sel_a), 0);
    chk("mid_rst_gv_a", int'(gv_a), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    va    = 8'h05;
    #1;
    chk("post_rst_sel0", int'(sel_a[0]), 0);
    chk("post_rst_gv0", int'(gv_a[0]), 1);

    // Three-slot groups: wrap modulo 3, tied-off slot never granted.
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 8'h00, 5'h1F, 5'h1F);
      chk($sformatf("b_rr_sel0 #%0d", i), int'(sel_b[0]), b_g0[i]);
      chk($sformatf("b_rr_sel1 #%0d", i), int'(sel_b[1]), b_g1[i]);
    end
    step(8'h00, 8'h00, 5'h00, 5'h00);
    chk("b_pad_ptr_sel1", int'(sel_b[1]), 2);
    chk("b_pad_gv1", int'(gv_b[1]), 0);
    chk("b_ptr_sel0", int'(sel_b[0]), 1);
    step(8'h00, 8'h00, 5'h08, 5'h00);
    chk("b_skip_pad_sel1", int'(sel_b[1]), 0);
    chk("b_skip_pad_gv1", int'(gv_b[1]), 1);
    step(8'h00, 8'h00, 5'h00, 5'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
